// File: rtl/jt89_pkg.sv
// Shared constants for the PSG tone and noise channels: field widths,
// attenuation magnitudes and the square-wave polarity encoding.
package jt89_pkg;

  localparam int unsigned PERIOD_W = 10;
  localparam int unsigned ATTEN_W  = 4;
  localparam int unsigned LUT_W    = 8;
  localparam int unsigned BASE_BW  = 9;

  // 2 dB per step magnitudes at the 9-bit base width; index 15 is silence
  localparam logic [LUT_W-1:0] ATTEN_LUT [16] = '{
    8'd255, 8'd203, 8'd161, 8'd128, 8'd102, 8'd81, 8'd64, 8'd51,
    8'd40,  8'd32,  8'd26,  8'd20,  8'd16,  8'd13, 8'd10, 8'd0
  };

  typedef enum logic {
    POL_LO = 1'b0,
    POL_HI = 1'b1
  } pol_e;

endpackage

// File: rtl/jt89_atten_lut.sv
// Attenuation index to unsigned output magnitude, scaled to the sample width.
// Purely combinational; the tone and noise channels each register the result.
module jt89_atten_lut
  import jt89_pkg::*;
#(
  parameter int unsigned bw = 9
) (
  input  logic [ATTEN_W-1:0] atten_i,
  output logic [bw-1:0]      mag_c_o
);

  localparam int unsigned SHIFT = bw - BASE_BW;

  // Largest entry is 255 << SHIFT, which always fits in bw-1 bits
  always_comb begin
    mag_c_o = bw'(ATTEN_LUT[atten_i]) << SHIFT;
  end

endmodule

// File: rtl/jt89_tone_src.sv
// SN76489-style square-wave tone channel: half-period down-counter driving a
// polarity FSM, followed by a two-stage signed amplitude path for the mixer.
module jt89_tone_src
  import jt89_pkg::*;
#(
  parameter int unsigned bw = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                cen_16,
  input  logic [PERIOD_W-1:0] period,
  input  logic [ATTEN_W-1:0]  atten,
  input  logic                restart,
  output logic [bw-1:0]       ch,
  output logic                flip
);

  localparam logic [PERIOD_W-1:0] DC_LIMIT = PERIOD_W'(2);
  localparam logic [PERIOD_W-1:0] ONE      = PERIOD_W'(1);

  pol_e                pol_q, pol_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                flip_q, flip_d;
  logic [bw-1:0]       amp_q, amp_d;
  logic [bw-1:0]       ch_q, ch_d;
  logic [bw-1:0]       lut_mag;
  logic                tick;
  logic                dc_mode;

  jt89_atten_lut #(
    .bw(bw)
  ) u_atten_lut (
    .atten_i (atten),
    .mag_c_o (lut_mag)
  );

  assign tick    = clk_en & cen_16;
  assign dc_mode = (period < DC_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol_q  <= POL_HI;
      cnt_q  <= '0;
      flip_q <= 1'b0;
      amp_q  <= '0;
      ch_q   <= '0;
    end else begin
      pol_q  <= pol_d;
      cnt_q  <= cnt_d;
      flip_q <= flip_d;
      amp_q  <= amp_d;
      ch_q   <= ch_d;
    end
  end

  // Counter/polarity FSM and amplitude pipeline; everything holds when clk_en=0
  always_comb begin
    pol_d  = pol_q;
    cnt_d  = cnt_q;
    flip_d = flip_q;
    amp_d  = amp_q;
    ch_d   = ch_q;
    if (clk_en) begin
      flip_d = 1'b0;
      amp_d  = lut_mag;
      ch_d   = (pol_q == POL_HI) ? amp_q : -amp_q;
      if (restart) begin
        cnt_d = period;
        pol_d = POL_HI;
      end else if (dc_mode) begin
        // Sample-playback mode: output pinned high, count frozen
        pol_d = POL_HI;
      end else if (tick) begin
        if (cnt_q <= ONE) begin
          cnt_d  = period;
          flip_d = 1'b1;
          case (pol_q)
            POL_HI:  pol_d = POL_LO;
            default: pol_d = POL_HI;
          endcase
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  assign ch   = ch_q;
  assign flip = flip_q;

endmodule
